// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: counter codes, entry layout,
// and PC index/tag extraction for a given index width.
package btb_pkg;

  localparam int CTR_W = 2;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Tag is held at its widest possible size (IDX_W = 0); upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    ctr_e        ctr;
  } btb_entry_t;

  function automatic logic [29:0] pc_idx(input logic [29:0] word, input int idx_w);
    return word & ((30'd1 << idx_w) - 30'd1);
  endfunction

  function automatic logic [29:0] pc_tag(input logic [29:0] word, input int idx_w);
    return word >> idx_w;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Lookup, training and statistics signals of the branch target buffer.
// master = fetch/EX side, slave = the BTB itself.
interface branch_target_buffer_if;
  logic        en;
  logic        inv_all_i;
  logic [31:0] pc_i;
  logic [31:0] EX_pc_i;
  logic        EX_is_br_i;
  logic        EX_br_taken_i;
  logic [31:0] EX_br_target_i;
  logic        EX_bp_pred_taken_i;
  logic        bp_pred_taken_o;
  logic [31:0] bp_pred_target_o;
  logic [31:0] stat_br_cnt_o;
  logic [31:0] stat_miss_cnt_o;

  modport master (
    output en, inv_all_i, pc_i, EX_pc_i, EX_is_br_i, EX_br_taken_i,
           EX_br_target_i, EX_bp_pred_taken_i,
    input  bp_pred_taken_o, bp_pred_target_o, stat_br_cnt_o, stat_miss_cnt_o
  );

  modport slave (
    input  en, inv_all_i, pc_i, EX_pc_i, EX_is_br_i, EX_br_taken_i,
           EX_br_target_i, EX_bp_pred_taken_i,
    output bp_pred_taken_o, bp_pred_target_o, stat_br_cnt_o, stat_miss_cnt_o
  );
endinterface

// File: rtl/bp_sat_ctr2.sv
// Combinational 2-bit saturating counter step: increment on taken, decrement otherwise.
module bp_sat_ctr2
  import btb_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_e'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters, zero-latency lookup, EX-side training.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_target_buffer_if.slave btb
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t tbl_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] tr_idx;
  logic [TAG_W-1:0] tr_tag;
  logic             tr_hit;
  logic             train_ev;
  ctr_e             tr_ctr_nxt;

  assign lk_idx = IDX_W'(pc_idx(btb.pc_i[31:2], IDX_W));
  assign lk_tag = TAG_W'(pc_tag(btb.pc_i[31:2], IDX_W));
  assign lk_hit = tbl_q[lk_idx].valid && (tbl_q[lk_idx].tag == 30'(lk_tag));

  // Lookup sees the registered table only, so a same-cycle train is not bypassed.
  always_comb begin
    btb.bp_pred_taken_o  = lk_hit && tbl_q[lk_idx].ctr[1];
    btb.bp_pred_target_o = 32'h0;
    if (btb.bp_pred_taken_o) btb.bp_pred_target_o = tbl_q[lk_idx].target;
  end

  assign tr_idx   = IDX_W'(pc_idx(btb.EX_pc_i[31:2], IDX_W));
  assign tr_tag   = TAG_W'(pc_tag(btb.EX_pc_i[31:2], IDX_W));
  assign tr_hit   = tbl_q[tr_idx].valid && (tbl_q[tr_idx].tag == 30'(tr_tag));
  assign train_ev = btb.en && btb.EX_is_br_i && !btb.inv_all_i;

  bp_sat_ctr2 u_sat_ctr (
    .ctr_i   (tbl_q[tr_idx].ctr),
    .taken_i (btb.EX_br_taken_i),
    .ctr_o   (tr_ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].ctr   <= WNT;
      end
    end else if (btb.inv_all_i) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
    end else if (train_ev) begin
      if (btb.EX_br_taken_i) begin
        tbl_q[tr_idx].target <= btb.EX_br_target_i;
        if (tr_hit) begin
          tbl_q[tr_idx].ctr <= tr_ctr_nxt;
        end else begin
          tbl_q[tr_idx].valid <= 1'b1;
          tbl_q[tr_idx].tag   <= 30'(tr_tag);
          tbl_q[tr_idx].ctr   <= WT;
        end
      end else if (tr_hit) begin
        tbl_q[tr_idx].ctr <= tr_ctr_nxt;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (train_ev) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (btb.EX_bp_pred_taken_i != btb.EX_br_taken_i) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign btb.stat_br_cnt_o   = br_cnt_q;
  assign btb.stat_miss_cnt_o = miss_cnt_q;
`else
  assign btb.stat_br_cnt_o   = 32'h0;
  assign btb.stat_miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES = 16).
module tb_branch_target_buffer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  branch_target_buffer_if btb_if_i ();

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btb   (btb_if_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    @(negedge clk);
    btb_if_i.pc_i = pc;
    #1;
    check({tag, "_taken"},  32'(btb_if_i.bp_pred_taken_o), 32'(exp_tk));
    check({tag, "_target"}, btb_if_i.bp_pred_target_o, exp_tgt);
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic pred, input logic en_v);
    @(negedge clk);
    btb_if_i.EX_pc_i            = pc;
    btb_if_i.EX_is_br_i         = 1'b1;
    btb_if_i.EX_br_taken_i      = tk;
    btb_if_i.EX_br_target_i     = tgt;
    btb_if_i.EX_bp_pred_taken_i = pred;
    btb_if_i.en                 = en_v;
    @(posedge clk);
    #1;
    btb_if_i.EX_is_br_i = 1'b0;
    btb_if_i.en         = 1'b1;
  endtask

  task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] miss);
`ifdef BTB_STATS_EN
    check({tag, "_br"},   btb_if_i.stat_br_cnt_o,   br);
    check({tag, "_miss"}, btb_if_i.stat_miss_cnt_o, miss);
`else
    check({tag, "_br"},   btb_if_i.stat_br_cnt_o,   32'h0);
    check({tag, "_miss"}, btb_if_i.stat_miss_cnt_o, 32'h0);
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    btb_if_i.en                 = 1'b1;
    btb_if_i.inv_all_i          = 1'b0;
    btb_if_i.pc_i               = 32'h0;
    btb_if_i.EX_pc_i            = 32'h0;
    btb_if_i.EX_is_br_i         = 1'b0;
    btb_if_i.EX_br_taken_i      = 1'b0;
    btb_if_i.EX_br_target_i     = 32'h0;
    btb_if_i.EX_bp_pred_taken_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    look("rst_0x100", 32'h100, 1'b0, 32'h0);
    stats("rst", 32'd0, 32'd0);

    // first allocation; lookup in the training cycle sees old contents
    @(negedge clk);
    btb_if_i.EX_pc_i            = 32'h100;
    btb_if_i.EX_is_br_i         = 1'b1;
    btb_if_i.EX_br_taken_i      = 1'b1;
    btb_if_i.EX_br_target_i     = 32'h180;
    btb_if_i.EX_bp_pred_taken_i = 1'b0;
    btb_if_i.pc_i               = 32'h100;
    #1 check("nobypass_taken", 32'(btb_if_i.bp_pred_taken_o), 32'h0);
    @(posedge clk);
    #1 btb_if_i.EX_is_br_i = 1'b0;
    look("alloc_0x100", 32'h100, 1'b1, 32'h180);
    look("alias_0x140", 32'h140, 1'b0, 32'h0);

    // counter walk from WT, including saturation at both ends
    train(32'h100, 1'b0, 32'h0,   1'b1, 1'b1); look("wnt",   32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0,   1'b0, 1'b1); look("snt",   32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0,   1'b0, 1'b1); look("snt_sat", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h180, 1'b0, 1'b1); look("snt_up", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h1C0, 1'b0, 1'b1); look("wt_newtgt", 32'h100, 1'b1, 32'h1C0);
    train(32'h100, 1'b1, 32'h1C0, 1'b1, 1'b1);
    train(32'h100, 1'b1, 32'h1C0, 1'b1, 1'b1); look("st_sat", 32'h100, 1'b1, 32'h1C0);
    train(32'h100, 1'b0, 32'h0,   1'b1, 1'b1); look("st_down", 32'h100, 1'b1, 32'h1C0);
    train(32'h100, 1'b0, 32'h0,   1'b1, 1'b1); look("wt_down", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h1C0, 1'b0, 1'b1); look("rewt",  32'h100, 1'b1, 32'h1C0);

    // not-taken miss allocates nothing; taken miss replaces
    train(32'h200, 1'b0, 32'h0,   1'b0, 1'b1);
    look("nt_miss_0x200", 32'h200, 1'b0, 32'h0);
    look("nt_miss_keep",  32'h100, 1'b1, 32'h1C0);
    train(32'h140, 1'b1, 32'h300, 1'b0, 1'b1);
    look("repl_0x140", 32'h140, 1'b1, 32'h300);
    look("repl_0x100", 32'h100, 1'b0, 32'h0);
    train(32'h104, 1'b1, 32'h400, 1'b0, 1'b1);
    look("idx1_0x104", 32'h104, 1'b1, 32'h400);

    // stall blocks training
    train(32'h108, 1'b1, 32'h500, 1'b0, 1'b0);
    look("stall_0x108", 32'h108, 1'b0, 32'h0);

    // invalidate beats a same-cycle train; lookup that cycle still uses old contents
    @(negedge clk);
    btb_if_i.inv_all_i      = 1'b1;
    btb_if_i.EX_pc_i        = 32'h10C;
    btb_if_i.EX_is_br_i     = 1'b1;
    btb_if_i.EX_br_taken_i  = 1'b1;
    btb_if_i.EX_br_target_i = 32'h600;
    btb_if_i.pc_i           = 32'h140;
    #1 check("inv_old_target", btb_if_i.bp_pred_target_o, 32'h300);
    @(posedge clk);
    #1;
    btb_if_i.inv_all_i  = 1'b0;
    btb_if_i.EX_is_br_i = 1'b0;
    look("inv_0x140", 32'h140, 1'b0, 32'h0);
    look("inv_0x104", 32'h104, 1'b0, 32'h0);
    look("inv_drop_0x10C", 32'h10C, 1'b0, 32'h0);

    // reset during a train discards the write and clears stats
    @(negedge clk);
    rst_n = 1'b0;
    train(32'h140, 1'b1, 32'h700, 1'b0, 1'b1);
    rst_n = 1'b1;
    look("rst_train_0x140", 32'h140, 1'b0, 32'h0);
    stats("rst2", 32'd0, 32'd0);

    // statistics: four train events, one mispredict, one stalled train ignored
    train(32'h100, 1'b1, 32'h180, 1'b1, 1'b1);
    train(32'h100, 1'b1, 32'h180, 1'b1, 1'b1);
    train(32'h100, 1'b1, 32'h180, 1'b0, 1'b0);
    train(32'h100, 1'b0, 32'h0,   1'b0, 1'b1);
    train(32'h104, 1'b1, 32'h900, 1'b0, 1'b1);
    look("stat_0x100", 32'h100, 1'b1, 32'h180);
    look("stat_0x104", 32'h104, 1'b1, 32'h900);
    stats("stat", 32'd4, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
